btn_cmd_scheduler: RTL and testbench

- Turns the debounced push-button levels into a single stream of command events for the image-processing control FSM.
- Detects press edges and generates auto-repeat on long holds.
- Queues at most one pending event per button and arbitrates them onto one valid/ready command port.
- Sits between the per-button debouncers and the mode/filter controller.

---
 rtl/btn_cmd_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_btn_cmd_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_scheduler.sv
// btn_cmd_scheduler
//   Turns debounced button levels into one stream of command events: a press
//   event on each rising edge, then auto-repeat events while the button stays
//   held. Each button can queue one pending event; pending events are
//   arbitrated onto a single registered valid/ready command port.
//   Optional build macro: BTN_SCHED_RR_EN selects round-robin arbitration.
//   When it is undefined, arbitration is fixed priority (lowest index wins).
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. Once cmd_valid is high, cmd_valid, cmd_id and
// cmd_repeat stay unchanged until that transfer; cmd_valid only drops after a
// transfer (or on reset). cmd_ready may be driven high or low at any time.
module btn_cmd_scheduler #(
    parameter int NUM_BTN       = 4,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    localparam int ID_W         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_db,
    input  logic               cmd_ready,
    output logic               cmd_valid,
    output logic [ID_W-1:0]    cmd_id,
    output logic               cmd_repeat,
    output logic [NUM_BTN-1:0] pending
);

    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] HOLD_TGT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TGT  = CNT_W'(REPEAT_CYCLES - 1);

    logic               armed;
    logic [NUM_BTN-1:0] btn_prev;
    // held: a press was seen and the button has not been released since.
    // Buttons already down at reset never become held, so they never repeat.
    logic [NUM_BTN-1:0] held;
    // in_repeat: first repeat already fired, counter now targets REP_TGT.
    logic [NUM_BTN-1:0] in_repeat;
    logic [CNT_W-1:0]   hold_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] rep;
    logic [NUM_BTN-1:0] press_ev;
    logic [NUM_BTN-1:0] rep_ev;
    logic [NUM_BTN-1:0] grant_hit;
    logic               slot_free;
    logic               grant_any;
    logic [ID_W-1:0]    grant_idx;

    // Arm on the first clock after reset and track the previous button levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            btn_prev <= '0;
        end else begin
            armed    <= 1'b1;
            btn_prev <= btn_db;
        end
    end

    // Per-button press-edge and repeat-expiry detection.
    always_comb begin
        press_ev = '0;
        rep_ev   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            press_ev[i] = armed & btn_db[i] & ~btn_prev[i];
            rep_ev[i]   = armed & held[i] & btn_db[i] &
                          (hold_cnt[i] == (in_repeat[i] ? REP_TGT : HOLD_TGT));
        end
    end

    // Hold counters: restart on press, release or repeat; count while held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                hold_cnt[i] <= '0;
            end
            held      <= '0;
            in_repeat <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!btn_db[i]) begin
                    hold_cnt[i]  <= '0;
                    held[i]      <= 1'b0;
                    in_repeat[i] <= 1'b0;
                end else if (press_ev[i]) begin
                    hold_cnt[i]  <= '0;
                    held[i]      <= 1'b1;
                    in_repeat[i] <= 1'b0;
                end else if (rep_ev[i]) begin
                    hold_cnt[i]  <= '0;
                    in_repeat[i] <= 1'b1;
                end else if (held[i]) begin
                    hold_cnt[i]  <= hold_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign slot_free = ~cmd_valid | cmd_ready;

`ifdef BTN_SCHED_RR_EN
    logic [ID_W-1:0] rr_ptr;

    // Button index reached by stepping 'off' places from 'base', wrapping.
    function automatic logic [ID_W-1:0] scan_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_BTN) begin
            sum = sum - NUM_BTN;
        end
        return ID_W'(sum);
    endfunction

    // Round-robin pointer moves just past each granted button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (slot_free && grant_any) begin
            rr_ptr <= scan_idx(grant_idx, 1);
        end
    end

    // Round-robin search from rr_ptr; scanned backwards so the nearest wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (pending[scan_idx(rr_ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx(rr_ptr, k);
            end
        end
        grant_hit = '0;
        if (slot_free && grant_any) begin
            grant_hit[grant_idx] = 1'b1;
        end
    end
`else
    // Fixed priority; scanned backwards so the lowest index wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (pending[k]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
        grant_hit = '0;
        if (slot_free && grant_any) begin
            grant_hit[grant_idx] = 1'b1;
        end
    end
`endif

    // Pending slots: press overwrites, repeat only fills an empty (or just
    // granted) slot, grant empties the slot unless a new event lands with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            rep     <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (press_ev[i]) begin
                    pending[i] <= 1'b1;
                    rep[i]     <= 1'b0;
                end else if (rep_ev[i] && (!pending[i] || grant_hit[i])) begin
                    pending[i] <= 1'b1;
                    rep[i]     <= 1'b1;
                end else if (grant_hit[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Registered command slot: load the granted event whenever the slot frees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_valid  <= 1'b0;
            cmd_id     <= '0;
            cmd_repeat <= 1'b0;
        end else if (slot_free) begin
            if (grant_any) begin
                cmd_valid  <= 1'b1;
                cmd_id     <= grant_idx;
                cmd_repeat <= rep[grant_idx];
            end else begin
                cmd_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// tb_btn_cmd_scheduler
//   Bench for btn_cmd_scheduler with NUM_BTN=4, HOLD_CYCLES=8, REPEAT_CYCLES=4.
//   Honours BTN_SCHED_RR_EN so the expected grant order follows the build.
module tb_btn_cmd_scheduler;

    localparam int NUM_BTN = 4;
    localparam int HOLD    = 8;
    localparam int REP     = 4;
`ifdef BTN_SCHED_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_db;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       cmd_repeat;
    logic [3:0] pending;

    btn_cmd_scheduler #(
        .NUM_BTN       (NUM_BTN),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_db     (btn_db),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_id     (cmd_id),
        .cmd_repeat (cmd_repeat),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    // entry: [19:4] expected first-valid cycle, [3] check cycle, [2:1] id, [0] repeat
    logic [19:0] exp_q[$];
    int model_ptr = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected command; every command corresponds to one grant, so the
    // round-robin model pointer advances here.
    task automatic push_cmd(input int id, input bit rpt, input bit chk, input int at);
        logic [19:0] e;
        e[19:4] = 16'(at);
        e[3]    = chk;
        e[2:1]  = 2'(id);
        e[0]    = rpt;
        exp_q.push_back(e);
        model_ptr = (id + 1) % NUM_BTN;
    endtask

    // Press commands for buttons that all rose together, in grant order.
    task automatic push_press_cmds(input logic [3:0] mask, input int first_at);
        logic [3:0] m;
        int at;
        int start;
        int pick;
        m  = mask;
        at = first_at;
        while (m != 4'b0000) begin
            start = RR_MODE ? model_ptr : 0;
            pick  = -1;
            for (int off = 0; off < NUM_BTN; off++) begin
                if (pick < 0 && m[(start + off) % NUM_BTN]) pick = (start + off) % NUM_BTN;
            end
            m[pick] = 1'b0;
            push_cmd(pick, 1'b0, 1'b1, at);
            at++;
        end
    endtask

    // Monitor: samples on the falling edge, checks handshake stability and
    // pops the expected queue on every transfer.
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [1:0] prev_id    = 2'd0;
    logic       prev_rep   = 1'b0;
    int         start_cyc  = 0;

    always @(negedge clk) begin
        logic [19:0] e;
        if (!reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check("hold_valid", int'(cmd_valid), 1);
                check("hold_stable", int'({cmd_id, cmd_repeat}), int'({prev_id, prev_rep}));
            end
            if (cmd_valid && (!prev_valid || prev_hs)) start_cyc = cyc;
            if (cmd_valid && cmd_ready) begin
                check("cmd_present", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("cmd_id", int'(cmd_id), int'(e[2:1]));
                    check("cmd_repeat", int'(cmd_repeat), int'(e[0]));
                    if (e[3]) check("cmd_cycle", start_cyc, int'(e[19:4]));
                end
            end
            prev_valid = cmd_valid;
            prev_hs    = cmd_valid && cmd_ready;
            prev_id    = cmd_id;
            prev_rep   = cmd_repeat;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] btn_during);
        reset     = 1'b0;
        btn_db    = btn_during;
        cmd_ready = 1'b1;
        exp_q.delete();
        model_ptr = 0;
        step(3);
        reset = 1'b1;
        step(2);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cmd_valid || pending != 4'b0000) && n < budget) begin
            step(1);
            n++;
        end
        check(name, int'(exp_q.size() == 0 && !cmd_valid && pending == 4'b0000), 1);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int c;
        logic [3:0] rnd;
        int n;

        vecs[0] = '{4'b0001, 3, 4'b0001};  // single press, 3 cycles
        vecs[1] = '{4'b0010, 1, 4'b0010};
        vecs[2] = '{4'b0100, 2, 4'b0100};
        vecs[3] = '{4'b1000, 4, 4'b1000};
        vecs[4] = '{4'b1010, 1, 4'b1010};  // simultaneous press
        vecs[5] = '{4'b0011, 2, 4'b0011};
        vecs[6] = '{4'b0101, 3, 4'b0101};
        vecs[7] = '{4'b1111, 2, 4'b1111};
        rnd = 4'($urandom_range(1, 15));
        vecs[8] = '{rnd, int'($urandom_range(1, 4)), rnd};
        rnd = 4'($urandom_range(1, 15));
        vecs[9] = '{rnd, int'($urandom_range(1, 4)), rnd};

        reset     = 1'b0;
        btn_db    = 4'b0000;
        cmd_ready = 1'b1;
        #3;
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_id", int'(cmd_id), 0);
        check("rst_repeat", int'(cmd_repeat), 0);
        check("rst_pending", int'(pending), 0);

        do_reset(4'b0000);

        // table: press patterns from idle, consumer always ready
        for (int v = 0; v < 10; v++) begin
            c = cyc;
            btn_db = vecs[v].btn;
            push_press_cmds(vecs[v].btn, c + 2);
            step(1);
            check($sformatf("vec%0d_pending", v), int'(pending), int'(vecs[v].exp_pend));
            if (vecs[v].hold > 1) step(vecs[v].hold - 1);
            btn_db = 4'b0000;
            wait_drain($sformatf("vec%0d_drain", v), 20);
            step(3);
        end

        // long hold on button 2: press then repeats 8,12,..,28 cycles later
        c = cyc;
        btn_db = 4'b0100;
        push_cmd(2, 1'b0, 1'b1, c + 2);
        for (int r = 0; r < 6; r++) push_cmd(2, 1'b1, 1'b1, c + 10 + 4 * r);
        step(30);
        btn_db = 4'b0000;
        wait_drain("hold_drain", 20);
        step(12);

        // backpressure: press stays presented, repeats coalesce into one
        cmd_ready = 1'b0;
        c = cyc;
        btn_db = 4'b0010;
        push_cmd(1, 1'b0, 1'b1, c + 2);
        push_cmd(1, 1'b1, 1'b0, 0);
        step(20);
        btn_db = 4'b0000;
        step(1);
        check("bp_valid", int'(cmd_valid), 1);
        check("bp_id", int'(cmd_id), 1);
        check("bp_repeat", int'(cmd_repeat), 0);
        check("bp_pending", int'(pending), 2);
        cmd_ready = 1'b1;
        wait_drain("bp_drain", 20);
        step(8);

        // order of a simultaneous press after button 1 was last granted
        c = cyc;
        btn_db = 4'b0010;
        push_press_cmds(4'b0010, c + 2);
        step(1);
        btn_db = 4'b0000;
        wait_drain("ptr_setup_drain", 20);
        step(2);
        c = cyc;
        btn_db = 4'b1010;
        push_press_cmds(4'b1010, c + 2);
        step(1);
        btn_db = 4'b0000;
        wait_drain("ptr_order_drain", 20);
        step(3);

        // button held through reset: silent until released and pressed again
        do_reset(4'b0100);
        step(15);
        check("held_valid", int'(cmd_valid), 0);
        check("held_pending", int'(pending), 0);
        btn_db = 4'b0000;
        step(2);
        c = cyc;
        btn_db = 4'b0100;
        push_cmd(2, 1'b0, 1'b1, c + 2);
        step(2);
        btn_db = 4'b0000;
        wait_drain("repress_drain", 20);
        step(3);

        // asynchronous reset while a command is waiting
        cmd_ready = 1'b0;
        btn_db = 4'b0110;
        step(1);
        btn_db = 4'b0000;
        n = 0;
        while (!cmd_valid && n < 10) begin
            step(1);
            n++;
        end
        check("mid_valid", int'(cmd_valid), 1);
        check("mid_id", int'(cmd_id), 1);
        check("mid_pending", int'(pending), 4);
        #2;
        reset = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        #1;
        check("async_valid", int'(cmd_valid), 0);
        check("async_id", int'(cmd_id), 0);
        check("async_pending", int'(pending), 0);
        step(2);
        reset = 1'b1;
        cmd_ready = 1'b1;
        step(12);
        check("post_reset_valid", int'(cmd_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
